// File: rtl/sram_rmw_pkg.sv
// Shared types and constants for the SRAM read-modify-write initiator.
package sram_rmw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RMW_READ  = 2'd1,
    ST_RMW_WRITE = 2'd2
  } rmw_state_e;

  localparam int unsigned RMW_CNT_WIDTH = 16;

  function automatic int unsigned byte_count(input int unsigned width);
    return (width + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Per-byte merge of a new word over an old word; the top byte may be narrower
// than 8 bits when DATA_WIDTH is not a multiple of 8.
module sram_byte_merge
  import sram_rmw_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned NUM_BYTES  = byte_count(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] old_word_i,
  input  logic [DATA_WIDTH-1:0] new_word_i,
  input  logic [NUM_BYTES-1:0]  ben_i,
  output logic [DATA_WIDTH-1:0] merged_o
);

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
    localparam int unsigned LO = 8 * i;
    localparam int unsigned W  = ((DATA_WIDTH - LO) < 8) ? (DATA_WIDTH - LO) : 8;
    assign merged_o[LO +: W] = ben_i[i] ? new_word_i[LO +: W] : old_word_i[LO +: W];
  end

endmodule

// File: rtl/sram_rmw_initiator.sv
// Requester-side SRAM controller: byte-enabled writes become read-modify-write.
// Define SRAM_RMW_STATS_EN to add the RmwCnt_DO completed-RMW counter.
module sram_rmw_initiator
  import sram_rmw_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned ADDR_WIDTH = 8,
  localparam int unsigned NUM_BYTES  = byte_count(DATA_WIDTH)
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Req_SI,
  output logic                  Gnt_SO,
  input  logic                  Wen_SI,
  input  logic [NUM_BYTES-1:0]  BEn_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  input  logic [DATA_WIDTH-1:0] WData_DI,
  output logic                  RValid_SO,
  output logic [DATA_WIDTH-1:0] RData_DO,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [NUM_BYTES-1:0]  BEn_SO,
  output logic [ADDR_WIDTH-1:0] SAddr_DO,
  output logic [DATA_WIDTH-1:0] SWrData_DO,
  input  logic [DATA_WIDTH-1:0] SRdData_DI
`ifdef SRAM_RMW_STATS_EN
  ,
  output logic [RMW_CNT_WIDTH-1:0] RmwCnt_DO
`endif
);

  rmw_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_BYTES-1:0]  ben_q, ben_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  rvalid_q, rvalid_d;
  logic                  ben_full, ben_none;

  assign ben_full = &BEn_SI;
  assign ben_none = ~|BEn_SI;

  sram_byte_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) i_byte_merge (
    .old_word_i(SRdData_DI),
    .new_word_i(wdata_q),
    .ben_i     (ben_q),
    .merged_o  (merged_word)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ben_d      = ben_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    rvalid_d   = 1'b0;
    Gnt_SO     = 1'b0;
    CSel_SO    = 1'b0;
    WrEn_SO    = 1'b0;
    SAddr_DO   = '0;
    SWrData_DO = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (Req_SI) begin
          Gnt_SO = 1'b1;
          if (!Wen_SI) begin
            CSel_SO  = 1'b1;
            SAddr_DO = Addr_DI;
            rvalid_d = 1'b1;
          end else if (ben_full) begin
            CSel_SO    = 1'b1;
            WrEn_SO    = 1'b1;
            SAddr_DO   = Addr_DI;
            SWrData_DO = WData_DI;
          end else if (!ben_none) begin
            // Read the old word now; it returns while in RMW_READ.
            CSel_SO  = 1'b1;
            SAddr_DO = Addr_DI;
            addr_d   = Addr_DI;
            ben_d    = BEn_SI;
            wdata_d  = WData_DI;
            state_d  = ST_RMW_READ;
          end
        end
      end
      ST_RMW_READ: begin
        merged_d = merged_word;
        state_d  = ST_RMW_WRITE;
      end
      ST_RMW_WRITE: begin
        CSel_SO    = 1'b1;
        WrEn_SO    = 1'b1;
        SAddr_DO   = addr_q;
        SWrData_DO = merged_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset must keep the SRAM untouched even though outputs are combinational.
    if (Rst_RI) begin
      Gnt_SO     = 1'b0;
      CSel_SO    = 1'b0;
      WrEn_SO    = 1'b0;
      SAddr_DO   = '0;
      SWrData_DO = '0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      ben_q    <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ben_q    <= ben_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign RValid_SO = rvalid_q & ~Rst_RI;
  assign RData_DO  = RValid_SO ? SRdData_DI : '0;
  assign BEn_SO    = '1;

`ifdef SRAM_RMW_STATS_EN
  logic [RMW_CNT_WIDTH-1:0] rmw_cnt_q, rmw_cnt_d;

  always_comb begin
    rmw_cnt_d = rmw_cnt_q;
    if ((state_q == ST_RMW_READ) && !(&rmw_cnt_q)) begin
      rmw_cnt_d = rmw_cnt_q + RMW_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      rmw_cnt_q <= '0;
    end else begin
      rmw_cnt_q <= rmw_cnt_d;
    end
  end

  assign RmwCnt_DO = rmw_cnt_q;
`endif

endmodule

// File: tb/tb_sram_rmw_initiator.sv
// Directed bench for sram_rmw_initiator (64-bit and 45-bit instances) with an
// SRAM model, a reference memory and a read-data scoreboard.
module tb_sram_rmw_initiator;

  logic        clk;
  logic        rst;
  logic        mem_init;

  logic        req, wen;
  logic [7:0]  ben, addr;
  logic [63:0] wdata;
  logic        gnt, rvalid, csel, wren;
  logic [63:0] rdata, swdata;
  logic [63:0] srdata;
  logic [7:0]  ben_o, saddr;

  logic        req45, wen45;
  logic [5:0]  ben45, ben45_o;
  logic [7:0]  addr45, saddr45;
  logic [44:0] wd45, rdata45, swdata45, srdata45;
  logic        gnt45, rvalid45, csel45, wren45;

`ifdef SRAM_RMW_STATS_EN
  logic [15:0] cnt, cnt45;
`endif

  logic [63:0] mem     [256];
  logic [44:0] mem45   [256];
  logic [63:0] ref_mem [256];
  logic [63:0] exp_q   [$];
  logic [63:0] sb_exp;
  logic [44:0] exp45;
  logic [63:0] old_word;

  int checks = 0;
  int passes = 0;

  int          w;
  logic        c, e, rv;
  logic [7:0]  sa;

  sram_rmw_initiator #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) u_dut (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req), .Gnt_SO(gnt), .Wen_SI(wen),
    .BEn_SI(ben), .Addr_DI(addr), .WData_DI(wdata), .RValid_SO(rvalid),
    .RData_DO(rdata), .CSel_SO(csel), .WrEn_SO(wren), .BEn_SO(ben_o),
    .SAddr_DO(saddr), .SWrData_DO(swdata), .SRdData_DI(srdata)
`ifdef SRAM_RMW_STATS_EN
    , .RmwCnt_DO(cnt)
`endif
  );

  sram_rmw_initiator #(.DATA_WIDTH(45), .ADDR_WIDTH(8)) u_dut45 (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req45), .Gnt_SO(gnt45), .Wen_SI(wen45),
    .BEn_SI(ben45), .Addr_DI(addr45), .WData_DI(wd45), .RValid_SO(rvalid45),
    .RData_DO(rdata45), .CSel_SO(csel45), .WrEn_SO(wren45), .BEn_SO(ben45_o),
    .SAddr_DO(saddr45), .SWrData_DO(swdata45), .SRdData_DI(srdata45)
`ifdef SRAM_RMW_STATS_EN
    , .RmwCnt_DO(cnt45)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input logic [7:0] a);
    return {8'hA5, a, 8'h3C, ~a, a ^ 8'h5A, a, 16'hBEEF};
  endfunction

  function automatic logic [63:0] merge64(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // Single-port SRAM models, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]   <= init_word(8'(i));
        mem45[i] <= '0;
      end
    end else begin
      if (csel) begin
        if (wren) mem[saddr] <= swdata;
        else      srdata     <= mem[saddr];
      end
      if (csel45) begin
        if (wren45) mem45[saddr45] <= swdata45;
        else        srdata45       <= mem45[saddr45];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_rdata", rdata, sb_exp);
      end
    end
  end

  task automatic do_req(input logic w_i, input logic [7:0] be_i, input logic [7:0] a_i,
                        input logic [63:0] d_i, output int waited, output logic o_csel,
                        output logic o_wren, output logic o_rv, output logic [7:0] o_saddr);
    req = 1'b1; wen = w_i; ben = be_i; addr = a_i; wdata = d_i;
    waited = 0;
    @(negedge clk);
    while (gnt !== 1'b1 && waited < 16) begin
      waited++;
      @(negedge clk);
    end
    o_csel = csel; o_wren = wren; o_rv = rvalid; o_saddr = saddr;
    if (gnt !== 1'b1) chk("gnt_timeout", 64'(gnt), 64'd1);
    else if (!w_i)    exp_q.push_back(ref_mem[a_i]);
    else              ref_mem[a_i] = merge64(ref_mem[a_i], d_i, be_i);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    req = 1'b1; wen = 1'b0; ben = '0; addr = 8'h55; wdata = '0;
    req45 = 1'b0; wen45 = 1'b0; ben45 = '0; addr45 = '0; wd45 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    exp45 = '0;
    for (int b = 40; b < 45; b++) exp45[b] = 1'b1;

    // Reset with a request pending.
    @(posedge clk); #1; mem_init = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt",    64'(gnt),    64'd0);
    chk("rst_csel",   64'(csel),   64'd0);
    chk("rst_wren",   64'(wren),   64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata",  rdata,       64'd0);
    chk("rst_saddr",  64'(saddr),  64'd0);
    chk("rst_swdata", swdata,      64'd0);
    chk("ben_o_ones", 64'(ben_o),  64'hFF);
    @(posedge clk); #1; rst = 1'b0; req = 1'b0;

    // Full write then read.
    do_req(1'b1, 8'hFF, 8'h10, 64'h0123456789ABCDEF, w, c, e, rv, sa);
    chk("fw_wait",  64'(w),  64'd0);
    chk("fw_csel",  64'(c),  64'd1);
    chk("fw_wren",  64'(e),  64'd1);
    chk("fw_saddr", 64'(sa), 64'h10);
    req = 1'b0;
    @(negedge clk); chk("fw_wren_pulse", 64'(wren), 64'd0);
    @(posedge clk); #1;
    do_req(1'b0, 8'h00, 8'h10, 64'd0, w, c, e, rv, sa);
    chk("rd_wait", 64'(w), 64'd0);
    chk("rd_csel", 64'(c), 64'd1);
    chk("rd_wren", 64'(e), 64'd0);
    req = 1'b0;
    @(negedge clk); chk("rd_latency", 64'(rvalid), 64'd1);
    @(posedge clk); #1;

    // Partial write over an all-ones word, followed at once by a read.
    do_req(1'b1, 8'hFF, 8'h20, 64'hFFFFFFFFFFFFFFFF, w, c, e, rv, sa);
    do_req(1'b1, 8'h0F, 8'h20, 64'd0, w, c, e, rv, sa);
    chk("pw_rd_sel",  64'(c), 64'd1);
    chk("pw_rd_wren", 64'(e), 64'd0);
    wen = 1'b0; ben = '0;
    @(negedge clk);
    chk("pw_gnt_c1",  64'(gnt),  64'd0);
    chk("pw_csel_c1", 64'(csel), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pw_gnt_c2", 64'(gnt),          64'd0);
    chk("pw_wr_sel", 64'({csel, wren}), 64'd3);
    chk("pw_saddr",  64'(saddr),        64'h20);
    chk("pw_wdata",  swdata,            ref_mem[8'h20]);
    @(posedge clk); #1;
    do_req(1'b0, 8'h00, 8'h20, 64'd0, w, c, e, rv, sa);
    chk("pw_rd_wait", 64'(w), 64'd0);
`ifdef SRAM_RMW_STATS_EN
    chk("pw_cnt", 64'(cnt), 64'd1);
`endif
    req = 1'b0;
    @(posedge clk); #1;

    // Back-to-back reads 0..7.
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 8'h00, 8'(i), 64'd0, w, c, e, rv, sa);
      chk("b2b_wait", 64'(w), 64'd0);
      if (i > 0) chk("b2b_rvalid", 64'(rv), 64'd1);
    end
    req = 1'b0;
    @(negedge clk); chk("b2b_rvalid_last", 64'(rvalid), 64'd1);
    @(posedge clk); #1;

    // Zero byte-enable write.
    do_req(1'b1, 8'h00, 8'h10, 64'hDEADBEEFCAFEF00D, w, c, e, rv, sa);
    chk("zb_wait", 64'(w), 64'd0);
    chk("zb_csel", 64'(c), 64'd0);
    do_req(1'b0, 8'h00, 8'h10, 64'd0, w, c, e, rv, sa);
    chk("zb_idle", 64'(w), 64'd0);
    req = 1'b0;
    @(posedge clk); #1;

    // Reset during RMW_READ drops the pending write.
    old_word = ref_mem[8'h30];
    do_req(1'b1, 8'h01, 8'h30, 64'hFFFFFFFFFFFFFFFF, w, c, e, rv, sa);
    ref_mem[8'h30] = old_word;
    rst = 1'b1; req = 1'b0;
    @(negedge clk); chk("rr_csel_c1", 64'(csel), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rr_no_wrsel", 64'(csel),   64'd0);
    chk("rr_wren",     64'(wren),   64'd0);
    chk("rr_saddr",    64'(saddr),  64'd0);
    chk("rr_swdata",   swdata,      64'd0);
    chk("rr_rvalid",   64'(rvalid), 64'd0);
    @(posedge clk); #1;
    do_req(1'b0, 8'h00, 8'h30, 64'd0, w, c, e, rv, sa);
    chk("rr_idle", 64'(w), 64'd0);
    req = 1'b0;
    @(posedge clk); #1;

    // 45-bit instance: write only the 5-bit top byte.
`ifdef SRAM_RMW_STATS_EN
    chk("w45_cnt_before", 64'(cnt45), 64'd0);
`endif
    req45 = 1'b1; wen45 = 1'b1; ben45 = 6'h20; addr45 = 8'h05; wd45 = '1;
    @(negedge clk);
    chk("w45_gnt",   64'(gnt45),            64'd1);
    chk("w45_rdsel", 64'({csel45, wren45}), 64'd2);
    @(posedge clk); #1; req45 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w45_wrsel",  64'({csel45, wren45}), 64'd3);
    chk("w45_swdata", 64'(swdata45),         64'(exp45));
    @(posedge clk); #1;
    req45 = 1'b1; wen45 = 1'b0; ben45 = '0;
    @(negedge clk); chk("r45_gnt", 64'(gnt45), 64'd1);
    @(posedge clk); #1; req45 = 1'b0;
    @(negedge clk);
    chk("r45_rvalid", 64'(rvalid45), 64'd1);
    chk("r45_rdata",  64'(rdata45),  64'(exp45));
`ifdef SRAM_RMW_STATS_EN
    chk("w45_cnt_after", 64'(cnt45), 64'd1);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
